// File: rtl/bp_dma_mem_responder.sv
// Memory-side responder for the cache DMA interface: accepts one packet at a time and
// streams out (read) or absorbs (write) one burst_len_p-beat block after a fixed latency.
module bp_dma_mem_responder #(
    parameter int addr_width_p = 28,
    parameter int data_width_p = 64,
    parameter int burst_len_p  = 8,
    parameter int mem_els_p    = 4096,
    parameter int latency_p    = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [addr_width_p:0]   dma_pkt_i,
    input  logic                    dma_pkt_v_i,
    output logic                    dma_pkt_yumi_o,
    output logic [data_width_p-1:0] dma_data_o,
    output logic                    dma_data_v_o,
    input  logic                    dma_data_ready_and_i,
    input  logic [data_width_p-1:0] dma_data_i,
    input  logic                    dma_data_v_i,
    output logic                    dma_data_yumi_o,
    output logic                    busy_o
);
    localparam int OffsetBits = $clog2(data_width_p / 8);
    localparam int IdxBits    = $clog2(mem_els_p);
    localparam int BeatBits   = $clog2(burst_len_p) + 1;
    localparam int LatBits    = $clog2(latency_p + 1) + 1;

    typedef enum logic [1:0] {StIdle, StWait, StRead, StWrite} state_e;

    state_e                  state_q, state_d;
    logic [IdxBits-1:0]      base_q, base_d;
    logic                    write_q, write_d;
    logic [BeatBits-1:0]     beat_q, beat_d;
    logic [LatBits-1:0]      lat_q, lat_d;
    logic [data_width_p-1:0] mem_q [mem_els_p];

    logic [addr_width_p-1:0] wordAddr;
    logic [IdxBits-1:0]      pktBase;
    logic [IdxBits-1:0]      beatIdx;
    logic                    lastBeat;
    logic                    wrBeat;

    // Truncating the word address to the array index is what makes upper bits alias.
    assign wordAddr = dma_pkt_i[addr_width_p-1:0] >> OffsetBits;
    assign pktBase  = IdxBits'(wordAddr) & ~IdxBits'(burst_len_p - 1);
    assign beatIdx  = base_q + IdxBits'(beat_q);
    assign lastBeat = (beat_q == BeatBits'(burst_len_p - 1));

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        write_d         = write_q;
        beat_d          = beat_q;
        lat_d           = lat_q;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_v_o    = 1'b0;
        dma_data_yumi_o = 1'b0;
        wrBeat          = 1'b0;
        unique case (state_q)
            StIdle: begin
                dma_pkt_yumi_o = dma_pkt_v_i;
                if (dma_pkt_v_i) begin
                    base_d  = pktBase;
                    write_d = dma_pkt_i[addr_width_p];
                    beat_d  = '0;
                    lat_d   = LatBits'(latency_p);
                    if (latency_p == 0) begin
                        state_d = dma_pkt_i[addr_width_p] ? StWrite : StRead;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                lat_d = lat_q - 1'b1;
                if (lat_q <= LatBits'(1)) begin
                    state_d = write_q ? StWrite : StRead;
                end
            end
            StRead: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_and_i) begin
                    beat_d = beat_q + 1'b1;
                    if (lastBeat) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrite: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    wrBeat = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (lastBeat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // A burst cut short by reset must not hand over or absorb a beat on that edge.
        if (reset_i) begin
            dma_pkt_yumi_o  = 1'b0;
            dma_data_v_o    = 1'b0;
            dma_data_yumi_o = 1'b0;
            wrBeat          = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            base_q  <= '0;
            write_q <= 1'b0;
            beat_q  <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            write_q <= write_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wrBeat) begin
            mem_q[beatIdx] <= dma_data_i;
        end
    end

    assign dma_data_o = mem_q[beatIdx];
    assign busy_o     = (state_q != StIdle);

endmodule
